// File: rtl/zeta_addr_sched_pkg.sv
// Shared sizing constants and status-FSM encoding for the zeta ROM address scheduler.
package zeta_addr_sched_pkg;

  localparam int NTT_STAGE_CNT = 8;
  localparam int NTT_STAGE_LAT = 2;
  localparam int ZETA_BEATS    = 2 ** (NTT_STAGE_CNT - 2);
  localparam int ZETA_ADDR_W   = NTT_STAGE_CNT - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } sched_state_e;

endpackage

// File: rtl/zeta_addr_sched_if.sv
// Beat input and per-stage ROM address/status bundle between datapath control and the scheduler.
interface zeta_addr_sched_if #(
  parameter int STAGE_CNT = zeta_addr_sched_pkg::NTT_STAGE_CNT
);
  localparam int AW = STAGE_CNT - 1;

  logic                                 in_valid;
  logic                                 in_inv;
  logic [1:0][STAGE_CNT-2:0][AW-1:0]    rom_addr;
  logic [STAGE_CNT-2:0]                 stage_valid;
  logic                                 busy;
  logic                                 frame_done;

  modport master (
    output in_valid, in_inv,
    input  rom_addr, stage_valid, busy, frame_done
  );

  modport slave (
    input  in_valid, in_inv,
    output rom_addr, stage_valid, busy, frame_done
  );

endinterface

// File: rtl/zeta_stage_cnt.sv
// One stage's beat counter, frame mode and registered two-lane twiddle addresses.
module zeta_stage_cnt
  import zeta_addr_sched_pkg::*;
#(
  parameter int STAGE     = 1,
  parameter int STAGE_CNT = NTT_STAGE_CNT,
  localparam int AW       = STAGE_CNT - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic          i_mode,
  output logic [AW-1:0] o_addr0,
  output logic [AW-1:0] o_addr1,
  output logic          o_valid,
  output logic          o_last
);

  localparam int KW = STAGE_CNT - 2;
  localparam int SH = AW - STAGE;
  localparam logic [AW-1:0] MASK = AW'((2 ** STAGE) - 1);

  logic [KW-1:0] r_k;
  logic          r_mode;
  logic [AW-1:0] r_addr0;
  logic [AW-1:0] r_addr1;
  logic          r_valid;
  logic          r_last;
  logic          w_mode;
  logic [AW-1:0] w_idx0;
  logic [AW-1:0] w_idx1;

  // Mode travels with beat 0 only; later beats reuse the latched value.
  always_comb begin
    w_mode = (r_k == '0) ? i_mode : r_mode;
    w_idx0 = {r_k, 1'b0} >> SH;
    w_idx1 = {r_k, 1'b1} >> SH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_mode  <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_last  <= i_valid && (r_k == '1);
      if (i_valid) begin
        r_k     <= r_k + 1'b1;
        r_mode  <= w_mode;
        r_addr0 <= w_mode ? (w_idx0 ^ MASK) : w_idx0;
        r_addr1 <= w_mode ? (w_idx1 ^ MASK) : w_idx1;
      end
    end
  end

  assign o_addr0 = r_addr0;
  assign o_addr1 = r_addr1;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/zeta_addr_sched.sv
// Zeta ROM address scheduler: delays the beat stream per stage and tracks frame status.
module zeta_addr_sched
  import zeta_addr_sched_pkg::*;
#(
  parameter int STAGE_CNT = NTT_STAGE_CNT,
  parameter int STAGE_LAT = NTT_STAGE_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  zeta_addr_sched_if.slave   bus
);

  localparam int AW = STAGE_CNT - 1;
  localparam int KW = STAGE_CNT - 2;
  localparam int DL = (STAGE_CNT - 2) * STAGE_LAT + 1;

  logic [KW-1:0]                      r_kin;
  logic                               r_fmode;
  logic [DL-2:0]                      r_dv;
  logic [DL-2:0]                      r_dm;
  logic                               w_mode_in;
  logic [DL-1:0]                      w_vtap;
  logic [DL-1:0]                      w_mtap;
  logic [AW-1:0]                      w_addr0 [STAGE_CNT-1];
  logic [AW-1:0]                      w_addr1 [STAGE_CNT-1];
  logic [STAGE_CNT-2:0]               w_sv;
  logic [STAGE_CNT-2:0]               w_last;
  logic [1:0][STAGE_CNT-2:0][AW-1:0]  w_rom;
  sched_state_e                       r_state;
  sched_state_e                       w_state_nxt;
  logic                               r_busy;

  assign w_mode_in = (r_kin == '0) ? bus.in_inv : r_fmode;
  // Tap 0 is the live input; stage j+1 reads tap j*STAGE_LAT.
  assign w_vtap = {r_dv, bus.in_valid};
  assign w_mtap = {r_dm, w_mode_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kin   <= '0;
      r_fmode <= 1'b0;
      r_dv    <= '0;
      r_dm    <= '0;
    end else begin
      r_dv <= w_vtap[DL-2:0];
      r_dm <= w_mtap[DL-2:0];
      if (bus.in_valid) begin
        r_kin <= r_kin + 1'b1;
        if (r_kin == '0) r_fmode <= bus.in_inv;
      end
    end
  end

  for (genvar j = 0; j < STAGE_CNT - 1; j++) begin : g_stage
    zeta_stage_cnt #(
      .STAGE     (j + 1),
      .STAGE_CNT (STAGE_CNT)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_vtap[j*STAGE_LAT]),
      .i_mode  (w_mtap[j*STAGE_LAT]),
      .o_addr0 (w_addr0[j]),
      .o_addr1 (w_addr1[j]),
      .o_valid (w_sv[j]),
      .o_last  (w_last[j])
    );
  end

  always_comb begin
    w_rom = '0;
    for (int unsigned j = 0; j < STAGE_CNT - 1; j++) begin
      w_rom[0][j] = w_addr0[j];
      w_rom[1][j] = w_addr1[j];
    end
  end

  // Idle only once the final stage closes a frame and no earlier beat is still travelling.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.in_valid) w_state_nxt = ST_RUN;
      ST_RUN:   if ((r_kin == '0) && !bus.in_valid) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.in_valid)
          w_state_nxt = ST_RUN;
        else if (w_last[STAGE_CNT-2] && !(|r_dv) && !(|w_last[STAGE_CNT-3:0]))
          w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.rom_addr    = w_rom;
  assign bus.stage_valid = w_sv;
  assign bus.frame_done  = w_last[STAGE_CNT-2];
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_zeta_addr_sched.sv
// Directed scoreboard bench for zeta_addr_sched at S=8, STAGE_LAT=2.
module tb_zeta_addr_sched;
  import zeta_addr_sched_pkg::*;

  localparam int S     = 8;
  localparam int LAT   = 2;
  localparam int NST   = S - 1;
  localparam int BEATS = 2 ** (S - 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  zeta_addr_sched_if #(.STAGE_CNT(S)) bif ();

  zeta_addr_sched #(
    .STAGE_CNT (S),
    .STAGE_LAT (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [6:0]  a0;
    logic [6:0]  a1;
  } exp_t;

  exp_t        sq [NST][$];
  int unsigned fq[$];
  int unsigned fd_obs[$];
  int unsigned cyc      = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned mkin     = 0;
  bit          mmode    = 1'b0;
  logic [6:0]  last0 [NST];
  logic [6:0]  last1 [NST];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] maddr(int unsigned k, int unsigned p, int unsigned i, bit inv);
    int unsigned b;
    int unsigned idx;
    b   = 2 * k + p;
    idx = b >> (NST - i);
    return inv ? 7'((1 << i) - 1 - idx) : 7'(idx);
  endfunction

  task automatic push_beat(bit inv);
    exp_t e;
    if (mkin == 0) mmode = inv;
    for (int i = 1; i <= NST; i++) begin
      e.due = 32'(cyc + 1 + (i - 1) * LAT);
      e.a0  = maddr(mkin, 0, i, mmode);
      e.a1  = maddr(mkin, 1, i, mmode);
      sq[i-1].push_back(e);
    end
    if (mkin == BEATS - 1) fq.push_back(cyc + 1 + (NST - 1) * LAT);
    mkin = (mkin + 1) % BEATS;
  endtask

  task automatic monitor();
    bit   pend;
    bit   expv;
    bit   expfd;
    exp_t e;
    pend = (mkin != 0) || (fq.size() != 0);
    for (int j = 0; j < NST; j++) if (sq[j].size() != 0) pend = 1'b1;
    check("busy", 128'(bif.busy), 128'(pend));
    for (int j = 0; j < NST; j++) begin
      expv = (sq[j].size() != 0) && (sq[j][0].due == cyc);
      check($sformatf("stage_valid%0d", j + 1), 128'(bif.stage_valid[j]), 128'(expv));
      if (expv) begin
        e = sq[j].pop_front();
        last0[j] = e.a0;
        last1[j] = e.a1;
      end
      check($sformatf("addr0_st%0d", j + 1), 128'(bif.rom_addr[0][j]), 128'(last0[j]));
      check($sformatf("addr1_st%0d", j + 1), 128'(bif.rom_addr[1][j]), 128'(last1[j]));
    end
    expfd = (fq.size() != 0) && (fq[0] == cyc);
    check("frame_done", 128'(bif.frame_done), 128'(expfd));
    if (expfd) void'(fq.pop_front());
    if (bif.frame_done === 1'b1) fd_obs.push_back(cyc);
  endtask

  task automatic step(bit v, bit inv);
    bif.in_valid = v;
    bif.in_inv   = inv;
    if (v && rst_n) push_beat(inv);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic clear_model();
    for (int j = 0; j < NST; j++) begin
      sq[j].delete();
      last0[j] = '0;
      last1[j] = '0;
    end
    fq.delete();
    mkin  = 0;
    mmode = 1'b0;
  endtask

  initial begin
    int unsigned f0;
    int unsigned nfd0;
    bif.in_valid = 1'b0;
    bif.in_inv   = 1'b0;
    clear_model();
    #1 rst_n = 1'b0;
    idle(3);
    check("reset_addr", 128'(bif.rom_addr), '0);
    rst_n = 1'b1;
    idle(2);

    // Forward frame
    f0 = cyc; nfd0 = fd_obs.size();
    for (int k = 0; k < BEATS; k++) begin
      step(1'b1, 1'b0);
      if (k == 12) begin
        check("fwd_st7_first_valid", 128'(bif.stage_valid[6]), 128'(1));
        check("fwd_st7_k0", 128'({bif.rom_addr[0][6], bif.rom_addr[1][6]}), 128'({7'd0, 7'd1}));
      end
      if (k == 20) check("fwd_st1_k20", 128'({bif.rom_addr[0][0], bif.rom_addr[1][0]}), 128'({7'd0, 7'd0}));
      if (k == 40) begin
        check("fwd_st1_k40", 128'({bif.rom_addr[0][0], bif.rom_addr[1][0]}), 128'({7'd1, 7'd1}));
        check("fwd_st7_k28", 128'({bif.rom_addr[0][6], bif.rom_addr[1][6]}), 128'({7'd56, 7'd57}));
      end
    end
    idle(20);
    check("fwd_fd_count", 128'(fd_obs.size() - nfd0), 128'(1));
    if (fd_obs.size() > nfd0) check("fwd_fd_cycle", 128'(fd_obs[nfd0] - f0), 128'(76));

    // Inverse frame, in_inv toggled after beat 0
    nfd0 = fd_obs.size();
    for (int k = 0; k < BEATS; k++) begin
      step(1'b1, (k == 0) ? 1'b1 : bit'(k % 2));
      if (k == 0) check("inv_st1_k0", 128'({bif.rom_addr[0][0], bif.rom_addr[1][0]}), 128'({7'd1, 7'd1}));
      if (k == 12) check("inv_st7_k0", 128'({bif.rom_addr[0][6], bif.rom_addr[1][6]}), 128'({7'd127, 7'd126}));
    end
    idle(20);
    check("inv_fd_count", 128'(fd_obs.size() - nfd0), 128'(1));

    // Gapped input
    nfd0 = fd_obs.size();
    for (int c = 0; c < 2 * BEATS; c++) step(bit'(c % 2 == 0), 1'b0);
    idle(20);
    check("gap_fd_count", 128'(fd_obs.size() - nfd0), 128'(1));

    // Back-to-back forward then inverse
    nfd0 = fd_obs.size();
    for (int k = 0; k < BEATS; k++) step(1'b1, 1'b0);
    for (int k = 0; k < BEATS; k++) begin
      step(1'b1, 1'b1);
      if (k == 11) check("b2b_st7_fwd_last", 128'({bif.rom_addr[0][6], bif.rom_addr[1][6]}), 128'({7'd126, 7'd127}));
      if (k == 12) check("b2b_st7_inv_first", 128'({bif.rom_addr[0][6], bif.rom_addr[1][6]}), 128'({7'd127, 7'd126}));
    end
    idle(20);
    check("b2b_fd_count", 128'(fd_obs.size() - nfd0), 128'(2));
    if (fd_obs.size() >= nfd0 + 2) check("b2b_fd_spacing", 128'(fd_obs[nfd0+1] - fd_obs[nfd0]), 128'(64));

    // Reset mid-frame at beat 40
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0);
    rst_n = 1'b0;
    bif.in_valid = 1'b0;
    #1;
    check("midrst_addr", 128'(bif.rom_addr), '0);
    check("midrst_sv", 128'(bif.stage_valid), '0);
    check("midrst_busy", 128'(bif.busy), '0);
    check("midrst_fd", 128'(bif.frame_done), '0);
    clear_model();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    f0 = cyc; nfd0 = fd_obs.size();
    for (int k = 0; k < BEATS; k++) step(1'b1, 1'b0);
    idle(20);
    check("post_rst_fd_count", 128'(fd_obs.size() - nfd0), 128'(1));
    if (fd_obs.size() > nfd0) check("post_rst_fd_cycle", 128'(fd_obs[nfd0] - f0), 128'(76));
    check("post_rst_busy_idle", 128'(bif.busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zeta_addr_sched.md
Name: zeta_addr_sched

Overview:
Address scheduler for the per-stage zeta ROMs of the pipelined NTT/INTT datapath. It receives the stream of butterfly beats entering the stage-0 butterfly. For every stage 1..S-1 it generates the two twiddle read addresses, one per butterfly lane, aligned to that stage's pipeline delay. Stage 0 needs no address because it has a single constant zeta. It also reports per-stage valid, busy and frame completion to the top-level NTT controller.

Parameters:
- STAGE_CNT, default `NTT_STAGE_CNT (8): number of NTT stages S.
- STAGE_LAT, default 2: cycles from a stage's input to the next stage's input. Legal range 1..8.
- Derived quantity BEATS = 2^(S-2): beats per frame, two butterflies per beat. Default 64.
- Derived quantity AW = S-1: ROM address width.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: one beat (two butterflies) enters stage 0 this cycle.
- in_inv, input, 1: 1 selects INTT ordering. Sampled on beat 0 of each frame only.
- rom_addr[2][S-1], output, AW each: element [p][j] drives lane p of stage j+1.
- stage_valid, output, S-1: bit j set means rom_addr[*][j] carries a live beat this cycle.
- busy, output, 1: some beat of a frame is still in flight.
- frame_done, output, 1: single-cycle pulse marking that stage S-1's last beat has been issued.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0: rom_addr, stage_valid, busy, frame_done.
  - The delay line, per-stage beat counters and per-stage mode bits are cleared.
- Reset mid-frame: the partial frame is discarded. The first in_valid after release is beat 0 of a new frame.
- All outputs are registered. There is no ready signal; the datapath is stall-free.
- Input counter:
  - kin counts 0..BEATS-1 and advances on in_valid.
  - At kin=0 the in_inv value is captured as the frame mode.
  - A valid/mode pair enters a delay line of depth (S-2)*STAGE_LAT+1.
- Timing:
  - If in_valid is high in cycle c with beat k, stage i (1..S-1) shows that beat in cycle c+1+(i-1)*STAGE_LAT.
  - In that cycle stage_valid[i-1]=1 and rom_addr[p][i-1] holds the address for beat k.
  - The ROM's one-cycle read latency is absorbed by the datapath.
- Address arithmetic for stage i, lane p, beat k:
  - b = 2k+p, which is (S-1) bits.
  - idx = b >> (S-1-i), giving the range 0..2^i-1.
  - Forward: addr = idx.
  - Inverse: addr = (2^i-1) - idx, i.e. the bitwise NOT of the low i bits.
  - Upper AW-i bits are always 0.
- Each stage keeps its own beat counter (0..BEATS-1). It advances only on that stage's delayed valid and wraps BEATS-1 -> 0.
- Mode is carried with beat 0 and held per stage for the whole frame. Consecutive frames may therefore differ in mode while overlapping in the pipeline.
- Gaps (in_valid=0):
  - stage_valid goes low at the matching delayed cycles.
  - rom_addr holds its last value and the counters hold.
- Back-to-back frames: beat 0 of frame n+1 may follow beat BEATS-1 of frame n in the next cycle with no bubble. The per-stage counters wrap cleanly.
- frame_done is asserted in the same cycle that stage_valid[S-2] is high with stage counter S-1 at BEATS-1.
- busy:
  - Equals (any delay-line valid set) OR (any stage counter nonzero) OR (kin nonzero).
  - Drops in the cycle after frame_done when nothing else is pending.
- State (explicit FSM held in the top-level status logic):
  - IDLE -> RUN on the first in_valid.
  - RUN -> DRAIN once kin wraps with no new beat.
  - DRAIN -> IDLE on frame_done with an empty delay line.
  - DRAIN -> RUN on a new in_valid.
  - busy is the registered form of (state != IDLE).

Decomposition:
- Add to ntt.svh:
  - `ZETA_BEATS, derived from `NTT_STAGE_CNT.
  - `ZETA_ADDR_W, derived from `NTT_STAGE_CNT.
  - `NTT_STAGE_LAT.
- Sub-module zeta_stage_cnt #(STAGE):
  - Owns one stage's beat counter, mode bit, two-lane address registers, stage_valid bit and last-beat flag.
  - Instanced S-1 times with a generate loop.

Test Plan:
- Forward frame, S=8, STAGE_LAT=2: 64 consecutive beats starting at cycle 0.
  - Stage 1: addr 0/0 for k<32, 1/1 for k>=32.
  - Stage 7: addr 2k/2k+1; stage 7 first valid at cycle 13.
  - frame_done at cycle 76, busy low from cycle 77.
- Inverse frame (in_inv=1 at beat 0, toggled afterwards):
  - Stage 7, k=0: addr 127/126.
  - Stage 1, k=0: addr 1/1.
  - Toggling in_inv after beat 0 has no effect.
- Gapped input: in_valid alternating 1/0 for 128 cycles.
  - stage_valid toggles at each stage delay; rom_addr is held through gaps.
  - Stage 3 sequence is idx = k>>3.
  - Exactly one frame_done.
- Back-to-back frames, forward then inverse, no bubble.
  - Stage 7 shows 126/127 then 127/126 on consecutive cycles.
  - Two frame_done pulses 64 cycles apart.
- rst_n pulled low at beat 40 while stages are active:
  - All outputs go to 0 immediately.
  - After release, a new frame starts at beat 0 with correct addresses and a single frame_done.
